// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-add signed multiplier.
package mult_pkg;

   localparam int WIDTH     = 8;
   localparam int NUM_STEPS = 8;
   localparam int CNT_W     = $clog2(NUM_STEPS);

   typedef enum logic [2:0] {
      IDLE,
      CLR,
      ADD,
      SHIFT,
      DONE
   } state_t;

endpackage

// File: rtl/mult_sequencer_if.sv
// Bus to the external 9-bit adder: operands out, sum and sign bit back.
interface mult_sequencer_if;
   import mult_pkg::*;

   logic [WIDTH-1:0] add_a;
   logic [WIDTH-1:0] add_s;
   logic             add_sub;
   logic [WIDTH-1:0] add_sum;
   logic             add_x;

   modport master (
      output add_a,
      output add_s,
      output add_sub,
      input  add_sum,
      input  add_x
   );

   modport slave (
      input  add_a,
      input  add_s,
      input  add_sub,
      output add_sum,
      output add_x
   );

endinterface

// File: rtl/mult_fsm.sv
// Control FSM: state register, step counter and datapath strobes.
module mult_fsm
   import mult_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic run,
   input  logic clear_load,
   output logic load_b,
   output logic clear,
   output logic do_add,
   output logic do_shift,
   output logic start,
   output logic add_sub,
   output logic done
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_STEPS - 1);

   state_t           state;
   state_t           state_n;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_n;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      load_b   = 1'b0;
      clear    = 1'b0;
      do_add   = 1'b0;
      do_shift = 1'b0;
      start    = 1'b0;
      add_sub  = 1'b0;
      done     = 1'b0;
      unique case (state)
         IDLE: begin
            if (clear_load) begin
               load_b = 1'b1;
            end else if (run) begin
               start   = 1'b1;
               state_n = CLR;
            end
         end
         CLR: begin
            clear   = 1'b1;
            cnt_n   = '0;
            state_n = ADD;
         end
         ADD: begin
            do_add  = 1'b1;
            // final step weights the multiplier sign bit negatively
            add_sub = (cnt == LAST);
            state_n = SHIFT;
         end
         SHIFT: begin
            do_shift = 1'b1;
            cnt_n    = cnt + CNT_W'(1);
            state_n  = (cnt == LAST) ? DONE : ADD;
         end
         DONE: begin
            done = 1'b1;
            if (!run) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: rtl/mult_sequencer.sv
// Signed 8x8 shift-add multiplier; product in {A,B}, adder is external.
// Define MULT_LATCH_S_EN to hold the multiplicand in a register during a run.
module mult_sequencer
   import mult_pkg::*;
(
   input  logic               Clk,
   input  logic               Reset,
   input  logic               Run,
   input  logic               ClearA_LoadB,
   input  logic [WIDTH-1:0]   SW,
   mult_sequencer_if.master   add,
   output logic [WIDTH-1:0]   Aval,
   output logic [WIDTH-1:0]   Bval,
   output logic               Xval,
   output logic               done
);

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             x_q;
   logic             load_b;
   logic             clear;
   logic             do_add;
   logic             do_shift;
   logic             start;
   logic             add_sub;

   mult_fsm u_fsm (
      .clk        (Clk),
      .reset      (Reset),
      .run        (Run),
      .clear_load (ClearA_LoadB),
      .load_b     (load_b),
      .clear      (clear),
      .do_add     (do_add),
      .do_shift   (do_shift),
      .start      (start),
      .add_sub    (add_sub),
      .done       (done)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         x_q <= 1'b0;
         a_q <= '0;
         b_q <= '0;
      end else if (load_b) begin
         x_q <= 1'b0;
         a_q <= '0;
         b_q <= SW;
      end else if (clear) begin
         x_q <= 1'b0;
         a_q <= '0;
      end else if (do_add && b_q[0]) begin
         {x_q, a_q} <= {add.add_x, add.add_sum};
      end else if (do_shift) begin
         // X is the sign, so it is replicated rather than consumed
         a_q <= {x_q, a_q[WIDTH-1:1]};
         b_q <= {a_q[0], b_q[WIDTH-1:1]};
      end
   end

`ifdef MULT_LATCH_S_EN
   logic [WIDTH-1:0] s_q;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         s_q <= '0;
      end else if (start) begin
         s_q <= SW;
      end
   end

   assign add.add_s = s_q;
`else
   logic unused_start;

   assign unused_start = start;
   assign add.add_s    = SW;
`endif

   assign add.add_a   = a_q;
   assign add.add_sub = add_sub;
   assign Aval        = a_q;
   assign Bval        = b_q;
   assign Xval        = x_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer with a behavioural 9-bit adder.
`timescale 1ns/1ps
module tb_mult_sequencer;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       Run;
   logic       ClearA_LoadB;
   logic [7:0] SW;
   logic [7:0] Aval;
   logic [7:0] Bval;
   logic       Xval;
   logic       done;
   logic [8:0] ext_a;
   logic [8:0] ext_s;
   logic [8:0] res;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [7:0]  b;
      logic [7:0]  s;
      logic [15:0] prod;
      logic        x;
   } vec_t;

   vec_t vecs [9];

   mult_sequencer_if add_bus ();

   mult_sequencer dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .Run          (Run),
      .ClearA_LoadB (ClearA_LoadB),
      .SW           (SW),
      .add          (add_bus),
      .Aval         (Aval),
      .Bval         (Bval),
      .Xval         (Xval),
      .done         (done)
   );

   always #5 Clk = ~Clk;

   always_comb begin
      ext_a = {add_bus.add_a[7], add_bus.add_a};
      ext_s = {add_bus.add_s[7], add_bus.add_s};
      res   = add_bus.add_sub ? (ext_a - ext_s) : (ext_a + ext_s);
   end

   assign add_bus.add_sum = res[7:0];
   assign add_bus.add_x   = res[8];

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic load_b(input logic [7:0] b);
      ClearA_LoadB = 1'b1;
      SW           = b;
      tick();
      ClearA_LoadB = 1'b0;
      check("load_b", int'(Bval), int'(b));
   endtask

   task automatic run_mult(input vec_t v);
      int n;
      int sub_hits;
      int sub_at;
      load_b(v.b);
      SW  = v.s;
      Run = 1'b1;
      tick();
      Run      = 1'b0;
      n        = 1;
      sub_hits = 0;
      sub_at   = 0;
      while (!done && n < 40) begin
         if (add_bus.add_sub) begin
            sub_hits++;
            sub_at = n;
         end
         tick();
         n++;
      end
      check("latency", n, 18);
      check("sub_hits", sub_hits, 1);
      check("sub_cycle", sub_at, 16);
      check("product", int'({Aval, Bval}), int'(v.prod));
      check("xval", int'(Xval), int'(v.x));
      tick();
      check("done_clr", int'(done), 0);
   endtask

   initial begin
      int n;
      int errs;
      vecs[0] = '{8'h3B, 8'h07, 16'h019D, 1'b0};
      vecs[1] = '{8'h3B, 8'hF9, 16'hFE63, 1'b1};
      vecs[2] = '{8'h80, 8'h80, 16'h4000, 1'b0};
      vecs[3] = '{8'h00, 8'h55, 16'h0000, 1'b0};
      vecs[4] = '{8'hFF, 8'h01, 16'hFFFF, 1'b1};
      vecs[5] = '{8'h7F, 8'h7F, 16'h3F01, 1'b0};
      vecs[6] = '{8'h80, 8'h7F, 16'hC080, 1'b1};
      vecs[7] = '{8'h01, 8'h80, 16'hFF80, 1'b1};
      vecs[8] = '{8'h05, 8'hFD, 16'hFFF1, 1'b1};

      Reset        = 1'b1;
      Run          = 1'b0;
      ClearA_LoadB = 1'b0;
      SW           = 8'h00;
      tick();
      tick();
      Reset = 1'b0;
      check("rst_a", int'(Aval), 0);
      check("rst_b", int'(Bval), 0);
      check("rst_x", int'(Xval), 0);
      check("rst_done", int'(done), 0);

      for (int i = 0; i < 9; i++) run_mult(vecs[i]);

      // reset in the middle of a multiply
      load_b(8'h3B);
      SW  = 8'h07;
      Run = 1'b1;
      tick();
      Run = 1'b0;
      repeat (8) tick();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      check("mid_rst_a", int'(Aval), 0);
      check("mid_rst_b", int'(Bval), 0);
      check("mid_rst_x", int'(Xval), 0);
      check("mid_rst_done", int'(done), 0);
      check("mid_rst_add_a", int'(add_bus.add_a), 0);
      load_b(8'h11);

      // Run held: done from cycle 18, no restart, idle only after release
      load_b(8'h3B);
      SW   = 8'h07;
      Run  = 1'b1;
      errs = 0;
      for (n = 1; n <= 30; n++) begin
         tick();
         if (done !== (n >= 18)) errs++;
      end
      check("held_done", errs, 0);
      check("held_prod", int'({Aval, Bval}), 16'h019D);
      Run = 1'b0;
      tick();
      check("held_release", int'(done), 0);
      load_b(8'h22);

      // Run and ClearA_LoadB ignored while busy
      load_b(8'h3B);
      SW  = 8'h07;
      Run = 1'b1;
      tick();
      ClearA_LoadB = 1'b1;
      n = 1;
      while (!done && n < 40) begin
         if (n == 17) begin
            Run          = 1'b0;
            ClearA_LoadB = 1'b0;
         end
         tick();
         n++;
      end
      check("busy_latency", n, 18);
      check("busy_prod", int'({Aval, Bval}), 16'h019D);
      Run          = 1'b0;
      ClearA_LoadB = 1'b0;
      tick();
      check("busy_done_clr", int'(done), 0);

`ifdef MULT_LATCH_S_EN
      load_b(8'h3B);
      SW  = 8'h07;
      Run = 1'b1;
      tick();
      Run = 1'b0;
      repeat (4) tick();
      SW = 8'h55;
      n  = 5;
      while (!done && n < 40) begin
         tick();
         n++;
      end
      check("latch_latency", n, 18);
      check("latch_prod", int'({Aval, Bval}), 16'h019D);
      tick();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
